dac_spi_serializer: RTL and testbench
=====================================

# dac_spi_serializer

Downstream stage of the AXI DAC interface: accepts the 12-bit DAC code it produces and ships it to an external 12-bit SPI DAC. Each accepted sample becomes one 16-bit frame (4-bit command + 12-bit code), MSB first, with programmable SCLK rate and inter-frame gap. A valid/ready handshake gives the upstream block back-pressure while a frame is in flight.

## Interface
- CLKDIV, 4: system clocks per SCLK half-period; legal range 1..255.
- CMD, 4'b0011: command nibble placed in frame bits [15:12] (write-and-update).
- FRAME_GAP, 2: idle cycles with CS_N high after a frame before the next sample is accepted; legal range 1..255.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- DATA  in  12  DAC code from the AXI DAC interface.
- DATA_VALID  in  1  DATA holds a sample to send.
- DATA_READY  out  1  serializer idle and able to accept a sample.
- SCLK  out  1  SPI clock, idle low; DAC samples MOSI on rising edge.
- MOSI  out  1  serial data, MSB first.
- CS_N  out  1  active-low frame select.
- BUSY  out  1  high from acceptance until return to IDLE.
- LDAC_N  out  1  load-DAC strobe (present only with DAC_SER_LDAC_EN).

## Operation
- Reset values: SCLK 0, MOSI 0, CS_N 1, DATA_READY 0, BUSY 0, LDAC_N 1; state IDLE. All outputs are registered.
- States: IDLE -> SHIFT -> GAP -> IDLE.
- IDLE: DATA_READY=1. Handshake = DATA_VALID && DATA_READY at a rising edge. On handshake, the shift register loads {CMD, DATA}, DATA_READY drops and BUSY rises. DATA may change after the handshake edge.
- SHIFT: CS_N=0. The frame is 16 SCLK periods, each CLKDIV cycles low then CLKDIV cycles high. MOSI carries bit 15 from frame start and advances one bit on each SCLK falling edge. No falling edge follows the 16th high phase.
- After the 16th high phase, SCLK returns low and CS_N rises in the same cycle. Go to GAP.
- GAP: CS_N=1, SCLK=0, MOSI=0. Lasts FRAME_GAP cycles, or FRAME_GAP+CLKDIV with LDAC enabled. Then IDLE with DATA_READY=1.
- DATA_VALID during SHIFT/GAP is ignored (no capture, no loss flag). Upstream holds it until the handshake.
- Counters: half-period counter width $clog2(CLKDIV+1); bit counter 4 bits (0..15, no wrap beyond 15).
- Reset mid-frame: CS_N goes high asynchronously, the frame is abandoned and the sample is lost. No resend after release.

## Timing
- Handshake edge t0. CS_N low and MOSI=bit15 from t0+1.
- SCLK rising edges at t0+1+CLKDIV+2k·CLKDIV, k=0..15.
- CS_N high at t0+1+32·CLKDIV.
- DATA_READY high at t0+1+32·CLKDIV+gap.
- Defaults (CLKDIV=4, FRAME_GAP=2):
  - CS_N low t0+1..t0+128.
  - CS_N high t0+129.
  - DATA_READY t0+131.
  - Throughput one sample per 131 cycles.
- Back-to-back: with DATA_VALID held high, the next handshake happens on the first cycle DATA_READY is high.
- First DATA_READY after reset release: the first rising edge following release.

## Configuration
- DAC_SER_LDAC_EN defined:
  - LDAC_N port exists.
  - GAP lengthens by CLKDIV cycles.
  - LDAC_N is low for the first CLKDIV cycles of GAP, starting the cycle CS_N rises (defaults: t0+129..t0+132, READY at t0+135).
- Undefined: no LDAC_N port; GAP = FRAME_GAP; the DAC updates on the CS_N rise via the CMD nibble.

## Structure
- Shared package dac_pkg:
  - state enum {IDLE, SHIFT, GAP}
  - DAC_DATA_W=12, DAC_CMD_W=4, DAC_FRAME_W=16
- Sub-module dac_spi_tick: half-period counter with enable.
  - Emits a one-cycle tick every CLKDIV cycles.
  - Restarts on enable rise.
  - Drives SCLK toggling and bit advance.

## Test plan
- Reset: hold RST low with DATA_VALID=1 -> CS_N=1, SCLK=0, DATA_READY=0. First edge after release -> DATA_READY=1. Next edge -> capture.
- Single frame, DATA=12'hA5C, defaults -> MOSI sampled at 16 SCLK rises = 16'h3A5C. CS_N low exactly 128 cycles. DATA_READY back at t0+131.
- Back-pressure: DATA_VALID held, DATA changes 12'h123->12'h456 mid-frame -> frame 1 = 16'h3123. 12'h456 accepted at t0+131 as frame 2 = 16'h3456.
- CLKDIV=1, FRAME_GAP=1, DATA=12'hFFF -> SCLK toggles every cycle. CS_N low 32 cycles. Frame 16'h3FFF. READY at t0+34.
- Reset at 7th SCLK rise -> CS_N=1 and SCLK=0 immediately. After release: no residual bits, READY on first edge.
- DAC_SER_LDAC_EN, DATA=12'h800 -> LDAC_N low t0+129..t0+132. READY at t0+135.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared types and widths for the SPI DAC serializer.
// Frame layout: {command nibble, 12-bit DAC code}, shifted MSB first.
package dac_pkg;

   localparam int DAC_DATA_W  = 12;
   localparam int DAC_CMD_W   = 4;
   localparam int DAC_FRAME_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP
   } state_t;

   function automatic logic [DAC_FRAME_W-1:0] dac_frame(
      input logic [DAC_CMD_W-1:0]  cmd,
      input logic [DAC_DATA_W-1:0] data
   );
      return {cmd, data};
   endfunction

endpackage

// File: rtl/dac_spi_tick.sv
// Half-period timebase: one-cycle tick every CLKDIV cycles while enabled.
// Counter is held clear while disabled, so each enable rise restarts the period.
module dac_spi_tick #(
   parameter int CLKDIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int            CW   = $clog2(CLKDIV + 1);
   localparam logic [CW-1:0] LAST = CW'(CLKDIV - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!en || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/dac_spi_serializer.sv
// 16-bit SPI frame serializer for a 12-bit DAC; ready only while idle, 32*CLKDIV+1 cycles per frame plus gap.
// Optional DAC_SER_LDAC_EN adds an LDAC_N strobe during the first CLKDIV cycles of the inter-frame gap.
module dac_spi_serializer
   import dac_pkg::*;
#(
   parameter int                   CLKDIV    = 4,
   parameter logic [DAC_CMD_W-1:0] CMD       = 4'b0011,
   parameter int                   FRAME_GAP = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DAC_DATA_W-1:0] DATA,
   input  logic                  DATA_VALID,
   output logic                  DATA_READY,
   output logic                  SCLK,
   output logic                  MOSI,
   output logic                  CS_N,
   output logic                  BUSY
`ifdef DAC_SER_LDAC_EN
   ,
   output logic                  LDAC_N
`endif
);

`ifdef DAC_SER_LDAC_EN
   localparam int GAP_LEN = FRAME_GAP + CLKDIV;
   localparam logic [8:0] LD_LAST = 9'(CLKDIV - 1);
`else
   localparam int GAP_LEN = FRAME_GAP;
`endif
   localparam logic [8:0] GAP_LAST = 9'(GAP_LEN - 1);

   state_t                 state;
   logic [DAC_FRAME_W-2:0] shreg;
   logic [3:0]             bit_cnt;
   logic [8:0]             gap_cnt;
   logic [DAC_FRAME_W-1:0] frame_in;
   logic                   tick;

   assign frame_in = dac_frame(CMD, DATA);

   dac_spi_tick #(.CLKDIV(CLKDIV)) u_tick (
      .clk   (CLK),
      .rst_n (RST),
      .en    (state == SHIFT),
      .tick  (tick)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         SCLK       <= 1'b0;
         MOSI       <= 1'b0;
         CS_N       <= 1'b1;
         DATA_READY <= 1'b0;
         BUSY       <= 1'b0;
`ifdef DAC_SER_LDAC_EN
         LDAC_N     <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (DATA_VALID && DATA_READY) begin
                  // Bit 15 goes straight to MOSI; the remaining 15 bits wait in shreg.
                  MOSI       <= frame_in[DAC_FRAME_W-1];
                  shreg      <= frame_in[DAC_FRAME_W-2:0];
                  bit_cnt    <= '0;
                  SCLK       <= 1'b0;
                  CS_N       <= 1'b0;
                  DATA_READY <= 1'b0;
                  BUSY       <= 1'b1;
                  state      <= SHIFT;
               end else begin
                  DATA_READY <= 1'b1;
               end
            end
            SHIFT: begin
               if (tick) begin
                  if (!SCLK) begin
                     SCLK <= 1'b1;
                  end else if (bit_cnt == 4'd15) begin
                     // End of the 16th high phase: no falling-edge data advance.
                     SCLK    <= 1'b0;
                     CS_N    <= 1'b1;
                     MOSI    <= 1'b0;
                     gap_cnt <= '0;
                     state   <= GAP;
`ifdef DAC_SER_LDAC_EN
                     LDAC_N  <= 1'b0;
`endif
                  end else begin
                     SCLK    <= 1'b0;
                     bit_cnt <= bit_cnt + 4'd1;
                     MOSI    <= shreg[DAC_FRAME_W-2];
                     shreg   <= {shreg[DAC_FRAME_W-3:0], 1'b0};
                  end
               end
            end
            GAP: begin
`ifdef DAC_SER_LDAC_EN
               if (gap_cnt == LD_LAST) begin
                  LDAC_N <= 1'b1;
               end
`endif
               if (gap_cnt == GAP_LAST) begin
                  DATA_READY <= 1'b1;
                  BUSY       <= 1'b0;
                  state      <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 9'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Scoreboard bench: instance 0 uses defaults, instance 1 uses CLKDIV=1, FRAME_GAP=1.
// A negedge monitor reassembles frames from SCLK rises and checks them against queued expectations.
module tb_dac_spi_serializer;

   typedef struct {
      logic [15:0] frame;
      int          cs_len;
      int          half;
      int          rdy;
      int          ld_start;
      int          ld_len;
   } exp_t;

`ifdef DAC_SER_LDAC_EN
   localparam int RDY0 = 135;
   localparam int RDY1 = 35;
`else
   localparam int RDY0 = 131;
   localparam int RDY1 = 34;
`endif

   logic        clk = 1'b0;
   logic [1:0]  rst;
   logic [1:0]  valid;
   logic [11:0] data [2];
   wire  [1:0]  ready, sclk, mosi, cs_n, busy;
`ifdef DAC_SER_LDAC_EN
   wire  [1:0]  ldac_n;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dac_spi_serializer dut0 (
      .CLK(clk), .RST(rst[0]), .DATA(data[0]), .DATA_VALID(valid[0]),
      .DATA_READY(ready[0]), .SCLK(sclk[0]), .MOSI(mosi[0]), .CS_N(cs_n[0]),
      .BUSY(busy[0])
`ifdef DAC_SER_LDAC_EN
      , .LDAC_N(ldac_n[0])
`endif
   );

   dac_spi_serializer #(.CLKDIV(1), .FRAME_GAP(1)) dut1 (
      .CLK(clk), .RST(rst[1]), .DATA(data[1]), .DATA_VALID(valid[1]),
      .DATA_READY(ready[1]), .SCLK(sclk[1]), .MOSI(mosi[1]), .CS_N(cs_n[1]),
      .BUSY(busy[1])
`ifdef DAC_SER_LDAC_EN
      , .LDAC_N(ldac_n[1])
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int qsize(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   // ---------------- monitor ----------------
   bit          active  [2] = '{0, 0};
   bit          pend    [2] = '{0, 0};
   bit          prv_cs  [2] = '{1, 1};
   bit          prv_rdy [2] = '{0, 0};
   bit          prv_sck [2] = '{0, 0};
   bit          bad     [2] = '{0, 0};
   int          t0      [2];
   int          cslen   [2];
   int          nbits   [2];
   int          run     [2];
   int          ld_st   [2];
   int          ld_len  [2];
   logic [15:0] sh      [2];
   exp_t        cur     [2];

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst[i]) begin
            active[i]  = 0;
            pend[i]    = 0;
            prv_cs[i]  = 1;
            prv_rdy[i] = 0;
         end else begin
`ifdef DAC_SER_LDAC_EN
            if (active[i] && !ldac_n[i]) begin
               if (ld_st[i] < 0) ld_st[i] = cyc + 1 - t0[i];
               ld_len[i]++;
            end
`endif
            if (active[i]) begin
               if (!cs_n[i]) begin
                  if (prv_cs[i]) begin
                     run[i]     = 1;
                     prv_sck[i] = sclk[i];
                  end else if (sclk[i] == prv_sck[i]) begin
                     run[i]++;
                  end else begin
                     if (run[i] != cur[i].half) bad[i] = 1;
                     run[i] = 1;
                     if (sclk[i]) begin
                        sh[i] = {sh[i][14:0], mosi[i]};
                        nbits[i]++;
                     end
                     prv_sck[i] = sclk[i];
                  end
                  cslen[i]++;
               end else if (!prv_cs[i]) begin
                  if (!prv_sck[i] || run[i] != cur[i].half) bad[i] = 1;
                  chk("frame", sh[i], cur[i].frame);
                  chk("bit_count", nbits[i], 16);
                  chk("cs_low_len", cslen[i], cur[i].cs_len);
                  chk("cs_rise_time", cyc + 1 - t0[i], cur[i].cs_len + 1);
                  chk("sclk_phase", bad[i], 0);
                  chk("gap_sclk", sclk[i], 0);
                  chk("gap_mosi", mosi[i], 0);
                  pend[i] = 1;
               end
            end
            prv_cs[i] = cs_n[i];
            if (ready[i] && !prv_rdy[i] && pend[i]) begin
               chk("ready_time", cyc + 1 - t0[i], cur[i].rdy);
               chk("busy_drop", busy[i], 0);
`ifdef DAC_SER_LDAC_EN
               chk("ldac_start", ld_st[i], cur[i].ld_start);
               chk("ldac_len", ld_len[i], cur[i].ld_len);
`endif
               pend[i]   = 0;
               active[i] = 0;
            end
            prv_rdy[i] = ready[i];
            if (valid[i] && ready[i]) begin
               if (qsize(i) == 0) begin
                  chk("sb_underflow", 1, 0);
               end else begin
                  cur[i]    = (i == 0) ? q0.pop_front() : q1.pop_front();
                  t0[i]     = cyc + 1;
                  active[i] = 1;
                  cslen[i]  = 0;
                  nbits[i]  = 0;
                  sh[i]     = '0;
                  bad[i]    = 0;
                  ld_st[i]  = -1;
                  ld_len[i] = 0;
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic push0(input logic [15:0] f);
      exp_t e;
      e = '{frame: f, cs_len: 128, half: 4, rdy: RDY0, ld_start: 129, ld_len: 4};
      q0.push_back(e);
   endtask

   task automatic push1(input logic [15:0] f);
      exp_t e;
      e = '{frame: f, cs_len: 32, half: 1, rdy: RDY1, ld_start: 33, ld_len: 1};
      q1.push_back(e);
   endtask

   task automatic wait_busy(input int i, input logic lvl);
      bit done = 0;
      for (int n = 0; n < 400 && !done; n++) begin
         @(posedge clk); #1;
         if (busy[i] == lvl) done = 1;
      end
      if (!done) chk("timeout_busy", 1, 0);
   endtask

   task automatic wait_idle(input int i);
      bit done = 0;
      for (int n = 0; n < 400 && !done; n++) begin
         @(posedge clk); #1;
         if (ready[i] && !active[i] && qsize(i) == 0) done = 1;
      end
      if (!done) chk("timeout_idle", 1, 0);
   endtask

   initial begin
      int c1, c2, nr;
      logic ps;
      rst      = 2'b00;
      valid    = 2'b01;
      data[0]  = 12'hA5C;
      data[1]  = 12'h000;
      push0(16'h3A5C);

      // Reset held with DATA_VALID asserted
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cs_n", cs_n, 2'b11);
      chk("rst_sclk", sclk, 2'b00);
      chk("rst_ready", ready, 2'b00);
      chk("rst_busy", busy, 2'b00);
      chk("rst_mosi", mosi, 2'b00);
`ifdef DAC_SER_LDAC_EN
      chk("rst_ldac", ldac_n, 2'b11);
`endif
      @(negedge clk);
      rst = 2'b11;
      @(posedge clk); #1;
      chk("first_ready", ready[0], 1);
      chk("first_busy", busy[0], 0);
      @(posedge clk); #1;
      chk("capture_busy", busy[0], 1);
      chk("capture_ready", ready[0], 0);
      chk("capture_cs_n", cs_n[0], 0);
      chk("capture_mosi", mosi[0], 0);
      valid[0] = 1'b0;
      data[0]  = 12'h000;
      wait_idle(0);

      // Back-pressure: DATA changes mid-frame, valid held across frames
      data[0]  = 12'h123;
      valid[0] = 1'b1;
      push0(16'h3123);
      push0(16'h3456);
      wait_busy(0, 1'b1);
      c1 = cyc;
      repeat (20) @(posedge clk);
      #1;
      data[0] = 12'h456;
      wait_busy(0, 1'b0);
      wait_busy(0, 1'b1);
      c2 = cyc;
      chk("b2b_spacing", c2 - c1, RDY0);
      valid[0] = 1'b0;
      wait_idle(0);

      // Fast instance: SCLK toggles every cycle
      data[1]  = 12'hFFF;
      valid[1] = 1'b1;
      push1(16'h3FFF);
      wait_busy(1, 1'b1);
      valid[1] = 1'b0;
      wait_idle(1);

      // Reset at the 7th SCLK rise; this frame is abandoned
      data[0]  = 12'h7E1;
      valid[0] = 1'b1;
      push0(16'h37E1);
      wait_busy(0, 1'b1);
      valid[0] = 1'b0;
      nr = 0;
      ps = sclk[0];
      for (int n = 0; n < 200 && nr < 7; n++) begin
         @(posedge clk); #1;
         if (sclk[0] && !ps) nr++;
         ps = sclk[0];
      end
      chk("sclk_rises_seen", nr, 7);
      #2;
      rst[0] = 1'b0;
      #1;
      chk("midrst_cs_n", cs_n[0], 1);
      chk("midrst_sclk", sclk[0], 0);
      chk("midrst_busy", busy[0], 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst[0] = 1'b1;
      chk("midrst_ready_low", ready[0], 0);
      @(posedge clk); #1;
      chk("midrst_ready_first_edge", ready[0], 1);
      data[0]  = 12'h3C1;
      valid[0] = 1'b1;
      push0(16'h33C1);
      wait_busy(0, 1'b1);
      valid[0] = 1'b0;
      wait_idle(0);

      // Frame used for the LDAC window when the strobe is built in
      data[0]  = 12'h800;
      valid[0] = 1'b1;
      push0(16'h3800);
      wait_busy(0, 1'b1);
      valid[0] = 1'b0;
      wait_idle(0);

      chk("sb_empty0", q0.size(), 0);
      chk("sb_empty1", q1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
